barrier_scanner: RTL and testbench

- Responder side of the man controller's movement interface.
- Once per frame it probes the tile map around the man's current bounding box and returns the barrier[3:0] free-to-move flags, using the same encoding the controller consumes.
- It also returns the dead/check hazard flags and the checkpoint origin.
- It sits between the man controller and the synchronous tile-map ROM.

---
 rtl/tile_pkg.sv | 40 ++++
 rtl/tile_addr_calc.sv | 26 ++
 rtl/barrier_scanner.sv | 191 +++++++++++++++++++
 tb/tb_barrier_scanner.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Tile-map types, screen geometry and probe/barrier indices shared by the
// barrier scanner and its address calculator.
package tile_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      SOLID = 2'b01,
      SPIKE = 2'b10,
      CHECK = 2'b11
   } tile_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_WAIT,
      ST_PUBLISH
   } scan_state_t;

   localparam int TILE_SHIFT = 5;
   localparam int MAP_COLS   = 20;
   localparam int MAP_ROWS   = 15;
   localparam int SCREEN_W   = 640;
   localparam int SCREEN_H   = 480;

   localparam logic [3:0] PROBE_RIGHT_TOP = 4'd0;
   localparam logic [3:0] PROBE_RIGHT_BOT = 4'd1;
   localparam logic [3:0] PROBE_LEFT_TOP  = 4'd2;
   localparam logic [3:0] PROBE_LEFT_BOT  = 4'd3;
   localparam logic [3:0] PROBE_UP_LEFT   = 4'd4;
   localparam logic [3:0] PROBE_UP_RIGHT  = 4'd5;
   localparam logic [3:0] PROBE_DN_LEFT   = 4'd6;
   localparam logic [3:0] PROBE_DN_RIGHT  = 4'd7;
   localparam logic [3:0] PROBE_CENTRE    = 4'd8;

   localparam int BARRIER_RIGHT = 0;
   localparam int BARRIER_LEFT  = 1;
   localparam int BARRIER_UP    = 2;
   localparam int BARRIER_DOWN  = 3;

endpackage

// File: rtl/tile_addr_calc.sv
// Maps a signed pixel coordinate to its tile column/row and ROM address,
// flagging points that fall outside the visible screen.
module tile_addr_calc
   import tile_pkg::*;
(
   input  logic signed [11:0] px_i,
   input  logic signed [11:0] py_i,
   output logic        [8:0]  tile_addr_o,
   output logic        [4:0]  col_o,
   output logic        [4:0]  row_o,
   output logic               oob_o
);

   logic [8:0] row_ext;

   always_comb begin
      col_o   = px_i[TILE_SHIFT +: 5];
      row_o   = py_i[TILE_SHIFT +: 5];
      row_ext = {4'b0000, row_o};
      // row*20 built from shifts; only meaningful when the point is on screen
      tile_addr_o = (row_ext << 4) + (row_ext << 2) + {4'b0000, col_o};
      oob_o = (int'(px_i) < 0) || (int'(px_i) > SCREEN_W - 1) ||
              (int'(py_i) < 0) || (int'(py_i) > SCREEN_H - 1);
   end

endmodule

// File: rtl/barrier_scanner.sv
// Once per frame, probes the tile map around the man's hitbox and publishes
// free-to-move flags, hazard flags and the last checkpoint origin.
module barrier_scanner
   import tile_pkg::*;
#(
   parameter int MAN_W   = 18,
   parameter int MAN_H   = 32,
   parameter int STEP_X  = 2,
   parameter int STEP_UP = 5,
   parameter int STEP_DN = 3
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_clk,
   input  logic        clear,
   input  logic [9:0]  man_x,
   input  logic [9:0]  man_y,
   output logic        tile_rd,
   output logic [8:0]  tile_addr,
   input  logic [1:0]  tile_data,
   output logic [3:0]  barrier,
   output logic        dead,
   output logic        check,
   output logic [9:0]  mapx,
   output logic [9:0]  mapy,
   output logic        scan_done,
   output scan_state_t state_dbg
);

   localparam logic signed [11:0] OFF_R  = 12'(MAN_W - 1);
   localparam logic signed [11:0] OFF_B  = 12'(MAN_H - 1);
   localparam logic signed [11:0] OFF_CX = 12'(MAN_W / 2);
   localparam logic signed [11:0] OFF_CY = 12'(MAN_H / 2);
   localparam logic signed [11:0] SX     = 12'(STEP_X);
   localparam logic signed [11:0] SU     = 12'(STEP_UP);
   localparam logic signed [11:0] SD     = 12'(STEP_DN);

   scan_state_t state_q, state_d;

   logic               fc_meta_q, fc_q, fc_prev_q, edge_q;
   logic signed [10:0] x_q, y_q;
   logic [3:0]         probe_q;
   logic [7:0]         solid_q;
   logic               pend_q;
   logic [2:0]         pend_idx_q;
   logic [4:0]         cen_col_q, cen_row_q;
   logic [3:0]         barrier_q;
   logic               dead_q, check_q;
   logic [9:0]         mapx_q, mapy_q;

   logic signed [11:0] x_s, y_s, r_s, b_s, px, py;
   logic [8:0]         calc_addr;
   logic [4:0]         calc_col, calc_row;
   logic               calc_oob;
   tile_t              cen_tile;

   always_comb begin
      x_s = {x_q[10], x_q};
      y_s = {y_q[10], y_q};
      r_s = x_s + OFF_R;
      b_s = y_s + OFF_B;
      px  = x_s + OFF_CX;
      py  = y_s + OFF_CY;
      case (probe_q)
         PROBE_RIGHT_TOP: begin px = r_s + SX; py = y_s;      end
         PROBE_RIGHT_BOT: begin px = r_s + SX; py = b_s;      end
         PROBE_LEFT_TOP:  begin px = x_s - SX; py = y_s;      end
         PROBE_LEFT_BOT:  begin px = x_s - SX; py = b_s;      end
         PROBE_UP_LEFT:   begin px = x_s;      py = y_s - SU; end
         PROBE_UP_RIGHT:  begin px = r_s;      py = y_s - SU; end
         PROBE_DN_LEFT:   begin px = x_s;      py = b_s + SD; end
         PROBE_DN_RIGHT:  begin px = r_s;      py = b_s + SD; end
         default: ;
      endcase
   end

   tile_addr_calc u_addr (
      .px_i        (px),
      .py_i        (py),
      .tile_addr_o (calc_addr),
      .col_o       (calc_col),
      .row_o       (calc_row),
      .oob_o       (calc_oob)
   );

   // An off-screen centre never reaches the ROM and reads as solid ground.
   assign cen_tile = pend_q ? tile_t'(tile_data) : SOLID;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    if (edge_q) state_d = ST_SCAN;
            ST_SCAN:    if (probe_q == PROBE_CENTRE) state_d = ST_WAIT;
            ST_WAIT:    state_d = ST_PUBLISH;
            ST_PUBLISH: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      tile_rd   = (state_q == ST_SCAN) && !calc_oob;
      tile_addr = (state_q == ST_SCAN) ? calc_addr : 9'd0;
      scan_done = (state_q == ST_PUBLISH);
      state_dbg = state_q;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fc_meta_q  <= 1'b0;
         fc_q       <= 1'b0;
         fc_prev_q  <= 1'b0;
         edge_q     <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         probe_q    <= '0;
         solid_q    <= '0;
         pend_q     <= 1'b0;
         pend_idx_q <= '0;
         cen_col_q  <= '0;
         cen_row_q  <= '0;
         barrier_q  <= '0;
         dead_q     <= 1'b0;
         check_q    <= 1'b0;
         mapx_q     <= '0;
         mapy_q     <= '0;
      end else begin
         fc_meta_q <= frame_clk;
         fc_q      <= fc_meta_q;
         fc_prev_q <= fc_q;
         edge_q    <= fc_q & ~fc_prev_q;
         if (clear) begin
            barrier_q <= '0;
            dead_q    <= 1'b0;
            check_q   <= 1'b0;
            pend_q    <= 1'b0;
            probe_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: if (edge_q) begin
                  x_q     <= {1'b0, man_x};
                  y_q     <= {1'b0, man_y};
                  probe_q <= '0;
                  solid_q <= '0;
                  pend_q  <= 1'b0;
               end
               ST_SCAN: begin
                  // ROM data for the previous slot lands while the next one issues
                  if (pend_q) solid_q[pend_idx_q] <= (tile_data == SOLID);
                  if (calc_oob && probe_q != PROBE_CENTRE) solid_q[probe_q[2:0]] <= 1'b1;
                  pend_q     <= !calc_oob;
                  pend_idx_q <= probe_q[2:0];
                  if (probe_q == PROBE_CENTRE) begin
                     cen_col_q <= calc_col;
                     cen_row_q <= calc_row;
                  end
                  probe_q <= probe_q + 4'd1;
               end
               ST_WAIT: begin
                  barrier_q[BARRIER_RIGHT] <= ~(solid_q[PROBE_RIGHT_TOP[2:0]] | solid_q[PROBE_RIGHT_BOT[2:0]]);
                  barrier_q[BARRIER_LEFT]  <= ~(solid_q[PROBE_LEFT_TOP[2:0]]  | solid_q[PROBE_LEFT_BOT[2:0]]);
                  barrier_q[BARRIER_UP]    <= ~(solid_q[PROBE_UP_LEFT[2:0]]   | solid_q[PROBE_UP_RIGHT[2:0]]);
                  barrier_q[BARRIER_DOWN]  <= ~(solid_q[PROBE_DN_LEFT[2:0]]   | solid_q[PROBE_DN_RIGHT[2:0]]);
                  dead_q  <= (cen_tile == SPIKE);
                  check_q <= (cen_tile == CHECK);
                  if (cen_tile == CHECK) begin
                     mapx_q <= {cen_col_q, 5'b00000};
                     mapy_q <= {cen_row_q, 5'b00000};
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign barrier = barrier_q;
   assign dead    = dead_q;
   assign check   = check_q;
   assign mapx    = mapx_q;
   assign mapy    = mapy_q;

endmodule

// File: tb/tb_barrier_scanner.sv
// Bench for barrier_scanner: tile ROM model, frame driver, reference model
// feeding expected queues, and a monitor that checks reads and publishes.
module tb_barrier_scanner;
   import tile_pkg::*;

   localparam int MAN_W   = 18;
   localparam int MAN_H   = 32;
   localparam int STEP_X  = 2;
   localparam int STEP_UP = 5;
   localparam int STEP_DN = 3;
   localparam int W       = 31;

   logic        Clk;
   logic        Reset_n;
   logic        frame_clk;
   logic        clear;
   logic [9:0]  man_x, man_y;
   logic        tile_rd;
   logic [8:0]  tile_addr;
   logic [1:0]  tile_data;
   logic [3:0]  barrier;
   logic        dead, check, scan_done;
   logic [9:0]  mapx, mapy;
   scan_state_t state_dbg;

   logic [1:0]   map [300];
   logic [W-1:0] exp_q[$];
   logic [8:0]   addr_q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rd_count = 0;
   int last_rd_cyc = 0;
   bit addr_chk_en = 1'b1;
   int model_mapx = 0;
   int model_mapy = 0;

   barrier_scanner dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .frame_clk (frame_clk),
      .clear     (clear),
      .man_x     (man_x),
      .man_y     (man_y),
      .tile_rd   (tile_rd),
      .tile_addr (tile_addr),
      .tile_data (tile_data),
      .barrier   (barrier),
      .dead      (dead),
      .check     (check),
      .mapx      (mapx),
      .mapy      (mapy),
      .scan_done (scan_done),
      .state_dbg (state_dbg)
   );

   // clock / reset-independent infrastructure
   initial Clk = 1'b0;
   always #10 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   initial tile_data = 2'b00;
   always @(posedge Clk) if (tile_rd) tile_data <= (tile_addr < 300) ? map[tile_addr] : 2'b00;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // reference model: geometry straight from the probe rules
   task automatic push_model(input int mx, input int my);
      int px[9];
      int py[9];
      int r, b, n, cc, cr;
      logic [1:0] code, cen;
      logic s[9];
      logic inb, cen_inb;
      logic [3:0] bar;
      r = mx + MAN_W - 1;
      b = my + MAN_H - 1;
      px = '{r + STEP_X, r + STEP_X, mx - STEP_X, mx - STEP_X, mx, r, mx, r, mx + MAN_W / 2};
      py = '{my, b, my, b, my - STEP_UP, my - STEP_UP, b + STEP_DN, b + STEP_DN, my + MAN_H / 2};
      n = 0; cc = 0; cr = 0; cen = 2'b01; cen_inb = 1'b0;
      for (int i = 0; i < 9; i++) begin
         inb = (px[i] >= 0) && (px[i] < 640) && (py[i] >= 0) && (py[i] < 480);
         if (inb) begin
            cc = px[i] / 32;
            cr = py[i] / 32;
            code = map[cr * 20 + cc];
            n++;
            addr_q.push_back(9'(cr * 20 + cc));
         end else begin
            code = 2'b01;
         end
         s[i] = (code == 2'b01);
         if (i == 8) begin cen = code; cen_inb = inb; end
      end
      bar = {!s[6] && !s[7], !s[4] && !s[5], !s[2] && !s[3], !s[0] && !s[1]};
      if (cen == 2'b11) begin model_mapx = cc * 32; model_mapy = cr * 32; end
      exp_q.push_back({cen_inb, 4'(n), 10'(model_mapy), 10'(model_mapx),
                       (cen == 2'b11), (cen == 2'b10), bar});
   endtask

   // monitor / scoreboard
   always @(negedge Clk) begin : mon
      logic [W-1:0] e;
      logic [8:0]   a;
      if (tile_rd) begin
         rd_count++;
         last_rd_cyc = cyc;
         if (addr_chk_en) begin
            checks++;
            if (addr_q.size() == 0) begin
               errors++;
               $display("FAIL rd_addr: unexpected read at addr=%0d, none required", tile_addr);
            end else begin
               a = addr_q.pop_front();
               if (tile_addr !== a) begin
                  errors++;
                  $display("FAIL rd_addr: got %0d, want %0d", tile_addr, a);
               end
            end
         end
      end
      if (scan_done) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scan_done: unexpected publish, bar=%b dead=%b chk=%b", barrier, dead, check);
         end else begin
            e = exp_q.pop_front();
            if ({mapy, mapx, check, dead, barrier} !== e[25:0]) begin
               errors++;
               $display("FAIL publish: got bar=%b dead=%b chk=%b mapx=%0d mapy=%0d, want bar=%b dead=%b chk=%b mapx=%0d mapy=%0d",
                        barrier, dead, check, mapx, mapy, e[3:0], e[4], e[5], e[15:6], e[25:16]);
            end
            checks++;
            if (rd_count != int'(e[29:26])) begin
               errors++;
               $display("FAIL rd_count: got %0d, want %0d", rd_count, e[29:26]);
            end
            if (e[30]) begin
               checks++;
               if (cyc - last_rd_cyc != 2) begin
                  errors++;
                  $display("FAIL publish_latency: got %0d cycles after centre read, want 2", cyc - last_rd_cyc);
               end
            end
         end
         rd_count = 0;
      end
   end

   // driver tasks
   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic frame_pulse();
      frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge Clk);
         t++;
      end
      check_val("scan_timeout", exp_q.size(), 0);
      exp_q.delete();
      repeat (4) @(negedge Clk);
   endtask

   task automatic wait_first_rd();
      int t = 0;
      while (!tile_rd && t < 30) begin
         @(negedge Clk);
         t++;
      end
      check_val("first_rd_seen", int'(tile_rd), 1);
   endtask

   task automatic run_scan(input int mx, input int my, input bit dbl);
      @(negedge Clk);
      man_x = 10'(mx);
      man_y = 10'(my);
      push_model(mx, my);
      frame_pulse();
      if (dbl) begin
         repeat (2) @(negedge Clk);
         frame_pulse();
      end
      wait_idle();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_barrier"}, barrier, 0);
      check_val({tag, "_dead"}, dead, 0);
      check_val({tag, "_check"}, check, 0);
      check_val({tag, "_mapx"}, mapx, 0);
      check_val({tag, "_mapy"}, mapy, 0);
      check_val({tag, "_tile_rd"}, tile_rd, 0);
      check_val({tag, "_scan_done"}, scan_done, 0);
   endtask

   initial begin
      for (int i = 0; i < 300; i++) map[i] = 2'b00;
      Reset_n = 1'b1; frame_clk = 1'b0; clear = 1'b0; man_x = '0; man_y = '0;
      #5 Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      check_reset_outputs("rst");
      check_val("rst_tile_addr", tile_addr, 0);
      Reset_n = 1'b1;
      repeat (10) @(negedge Clk);
      check_val("idle_no_rd", rd_count, 0);

      // open field, floor with a second edge mid-scan, left screen edge
      run_scan(64, 64, 1'b0);
      for (int c = 0; c < 20; c++) map[14 * 20 + c] = 2'b01;
      run_scan(32, 416, 1'b1);
      for (int c = 0; c < 20; c++) map[14 * 20 + c] = 2'b00;
      run_scan(1, 64, 1'b0);

      // hazards
      map[5 * 20 + 5]  = 2'b10;
      run_scan(160, 160, 1'b0);
      map[10 * 20 + 3] = 2'b11;
      run_scan(96, 320, 1'b0);
      run_scan(200, 320, 1'b0);
      run_scan(160, 160, 1'b0);

      // clear mid-scan, then a frame edge while clear is held
      addr_chk_en = 1'b0;
      @(negedge Clk);
      frame_clk = 1'b1;
      wait_first_rd();
      repeat (3) @(negedge Clk);
      clear = 1'b1;
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
      check_val("clear_barrier", barrier, 0);
      check_val("clear_dead", dead, 0);
      check_val("clear_check", check, 0);
      check_val("clear_mapx_held", mapx, model_mapx);
      check_val("clear_mapy_held", mapy, model_mapy);
      rd_count = 0;
      frame_pulse();
      repeat (20) @(negedge Clk);
      check_val("clear_no_rd", rd_count, 0);
      clear = 1'b0;
      addr_q.delete();
      rd_count = 0;
      addr_chk_en = 1'b1;
      repeat (2) @(negedge Clk);
      run_scan(96, 320, 1'b0);

      // asynchronous reset in the middle of a scan
      addr_chk_en = 1'b0;
      @(negedge Clk);
      frame_clk = 1'b1;
      wait_first_rd();
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
      #3 Reset_n = 1'b0;
      #1 check_reset_outputs("midrst");
      model_mapx = 0;
      model_mapy = 0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      addr_q.delete();
      rd_count = 0;
      addr_chk_en = 1'b1;
      repeat (4) @(negedge Clk);

      // randomized maps and positions
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            map[i] = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
         end
         run_scan($urandom_range(0, 700), $urandom_range(0, 520), 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge Clk);
      check_val("addr_q_empty", addr_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
